mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative multiply/divide unit in the execute stage. Executes MULT/MULTU/DIV/DIVU and
//   MTHI/MTLO, and owns the HI/LO registers. Drives mult_done into the hazard unit, which
//   holds the front of the pipeline while mult_done is low. One result bit per cycle.
// PARAMETERS
//   WIDTH   32   operand width; HI and LO are WIDTH each; iteration count = WIDTH
// PORTS
//   clk        in   1      rising-edge clock (single clock domain)
//   reset      in   1      asynchronous, active-high reset
//   start_e    in   1      valid op in execute this cycle (gated off by flush_e upstream)
//   op_e       in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   srca_e     in   WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
//   srcb_e     in   WIDTH  rt operand: multiplier or divisor
//   hi_out     out  WIDTH  architectural HI
//   lo_out     out  WIDTH  architectural LO
//   mult_done  out  1      1 = idle and not accepting a multi-cycle op this cycle
//   busy       out  1      1 = in RUN or FIXUP (registered)
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, hi_out=lo_out=0, count=0, busy=0, mult_done=1.
//   States: IDLE -> RUN -> FIXUP -> IDLE.
//   IDLE: start_e & op_e in {MULT,MULTU,DIV,DIVU}: latch op and magnitudes
//     (signed ops take abs value; record sign_q = sa^sb, sign_r = sa), count=0, go to RUN.
//     start_e & MTHI: hi_out<=srca_e. start_e & MTLO: lo_out<=srca_e. Both take 1 cycle,
//     stay in IDLE. op_e 110/111: no effect.
//   mult_done = (state==IDLE) & ~(start_e & ~op_e[2]). This is combinational, so it
//     drops in the same cycle a mul/div is presented and the hazard unit stalls at once.
//   RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle. count
//     increments; after the step with count==WIDTH-1, go to FIXUP.
//   FIXUP: apply signs. Mul: negate the 2*WIDTH product if sign_q. Div: negate quotient
//     if sign_q, negate remainder if sign_r. Write HI/LO, go to IDLE.
//   Latency: start cycle C0 (IDLE); RUN C1..C32; FIXUP C33. New hi_out/lo_out and
//     mult_done=1 are visible from C34. mult_done is low for C0..C33 (34 cycles).
//   Results: mul: {HI,LO} = full 2*WIDTH product. div: LO = quotient, HI = remainder,
//     truncated toward zero.
//   Divide by zero (srcb_e==0, signed or unsigned): full latency still applies;
//     HI = srca_e as latched (original sign), LO = all ones.
//   Signed edge case: 0x80000000 / -1 gives LO=0x80000000, HI=0 (wraps, no trap).
//   start_e while busy: ignored; operands and op are not re-latched. The hazard stall
//     means this cannot occur legally.
//   hi_out/lo_out hold their old values throughout RUN. They update only at the
//     FIXUP edge or on MTHI/MTLO.
// STRUCTURE
//   Package mdu_pkg: MDU_MULT..MDU_MTLO op localparams; state encoding
//     (IDLE=2'd0, RUN=2'd1, FIXUP=2'd2); MDU_ITER = WIDTH.
//   Sub-module mdu_step: combinational single-iteration datapath. Inputs: mode, partial
//     {hi,lo}, operand. Outputs: next {hi,lo}. mult_div_unit holds the FSM, counter,
//     sign flags and HI/LO.
// TESTING
//   MULTU a=0xFFFFFFFF b=2 -> mult_done low 34 cycles; then HI=0x00000001, LO=0xFFFFFFFE.
//   MULT a=-3 b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV a=-7 b=2 -> LO=0xFFFFFFFD (-3),
//     HI=0xFFFFFFFF (-1).
//   DIVU a=7 b=0 -> HI=0x00000007, LO=0xFFFFFFFF after 34 cycles.
//   MTHI 0x12345678 in IDLE -> hi_out=0x12345678 next cycle, mult_done stays 1.
//     MTLO while busy -> ignored.
//   reset asserted mid-RUN (count=10), asynchronously off the clock edge -> mult_done=1,
//     busy=0, HI=LO=0 immediately. A new MULTU 3*4 afterwards -> LO=12, HI=0.
//   Second MULT on start_e at C5 of a running op -> ignored; first op's result unchanged.
//     mult_done is never high while busy=1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, iteration count.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = MDU_WIDTH;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage request and result bundle for the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start_e;
  logic [2:0]       op_e;
  logic [WIDTH-1:0] srca_e;
  logic [WIDTH-1:0] srcb_e;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             mult_done;
  logic             busy;

  modport master (
    output start_e, op_e, srca_e, srcb_e,
    input  hi_out, lo_out, mult_done, busy
  );

  modport slave (
    input  start_e, op_e, srca_e, srcb_e,
    output hi_out, lo_out, mult_done, busy
  );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring shift-subtract divide.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  always_comb begin
    w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : '0);
    // Shifted partial remainder needs one extra bit before the compare.
    w_rem  = {i_hi, i_lo[WIDTH-1]};
    w_fits = (w_rem >= {1'b0, i_operand});
    w_diff = w_rem[WIDTH-1:0] - i_operand;
    o_hi   = '0;
    o_lo   = '0;
    if (i_div) begin
      o_hi = w_fits ? w_diff : w_rem[WIDTH-1:0];
      o_lo = {i_lo[WIDTH-2:0], w_fits};
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one result bit per cycle, signs applied in FIXUP.
module mult_div_unit import mdu_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t       r_state;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_is_div;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_operand;

  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign w_signed = ~bus.op_e[0];
  assign w_sa     = w_signed & bus.srca_e[WIDTH-1];
  assign w_sb     = w_signed & bus.srcb_e[WIDTH-1];
  assign w_mag_a  = f_neg(bus.srca_e, w_sa);
  assign w_mag_b  = f_neg(bus.srcb_e, w_sb);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_div     (r_is_div),
    .i_hi      (r_acc_hi),
    .i_lo      (r_acc_lo),
    .i_operand (r_operand),
    .o_hi      (w_step_hi),
    .o_lo      (w_step_lo)
  );

  // Combinational so the hazard unit stalls in the same cycle a mul/div is presented.
  assign bus.mult_done = (r_state == ST_IDLE) & ~(bus.start_e & ~bus.op_e[2]);
  assign bus.busy      = r_busy;
  assign bus.hi_out    = r_hi;
  assign bus.lo_out    = r_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_is_div  <= 1'b0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_operand <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_e) begin
            case (bus.op_e)
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                r_is_div  <= bus.op_e[1];
                r_sign_q  <= w_sa ^ w_sb;
                r_sign_r  <= w_sa;
                r_acc_hi  <= '0;
                r_acc_lo  <= bus.op_e[1] ? w_mag_a : w_mag_b;
                r_operand <= bus.op_e[1] ? w_mag_b : w_mag_a;
                r_count   <= '0;
                r_busy    <= 1'b1;
                r_state   <= ST_RUN;
              end
              MDU_MTHI: r_hi <= bus.srca_e;
              MDU_MTLO: r_lo <= bus.srca_e;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          r_count  <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) r_state <= ST_FIXUP;
        end
        ST_FIXUP: begin
          // A zero divisor leaves the dividend magnitude in acc_hi, so the remainder
          // sign fixup restores the original dividend; only the quotient is forced.
          if (r_is_div) begin
            r_lo <= (r_operand == '0) ? '1 : f_neg(r_acc_lo, r_sign_q);
            r_hi <= f_neg(r_acc_hi, r_sign_r);
          end else begin
            {r_hi, r_lo} <= f_neg2({r_acc_hi, r_acc_lo}, r_sign_q);
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed spec vectors, MTHI/MTLO, async reset, random ops vs model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // mult_done must never be high while a multi-cycle op is in flight.
  always @(negedge clk) begin
    if (!reset && bus.busy === 1'b1) begin
      vectors++;
      if (bus.mult_done !== 1'b0) begin
        miscompares++;
        $display("FAIL done_while_busy: mult_done=%b want 0 at %0t", bus.mult_done, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain arithmetic on the architectural definitions.
  function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sb;
    int     ia, ib;
    logic [63:0] p;
    hi = '0; lo = '0;
    case (op)
      MDU_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        hi = p[63:32]; lo = p[31:0];
      end
      MDU_MULTU: begin
        p  = {32'b0, a} * {32'b0, b};
        hi = p[63:32]; lo = p[31:0];
      end
      MDU_DIV: begin
        ia = $signed(a);
        ib = $signed(b);
        if (b == 0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'h0; lo = 32'h8000_0000;
        end else begin
          lo = 32'(ia / ib);
          hi = 32'(ia % ib);
        end
      end
      MDU_DIVU: begin
        if (b == 0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic md0);
    @(negedge clk);
    bus.start_e = 1'b1;
    bus.op_e    = op;
    bus.srca_e  = a;
    bus.srcb_e  = b;
    #1 md0 = bus.mult_done;
    @(posedge clk);
    @(negedge clk);
    bus.start_e = 1'b0;
    bus.srca_e  = $urandom;
    bus.srcb_e  = $urandom;
  endtask

  // Returns cycles with mult_done low, counting the start cycle; caller enters at the first RUN negedge.
  task automatic wait_done(output int cycles);
    cycles = 1;
    while (bus.mult_done !== 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors += 4;
    if (bus.hi_out !== 32'h0)     begin miscompares++; $display("FAIL reset_hi: got %h want 0", bus.hi_out); end
    if (bus.lo_out !== 32'h0)     begin miscompares++; $display("FAIL reset_lo: got %h want 0", bus.lo_out); end
    if (bus.mult_done !== 1'b1)   begin miscompares++; $display("FAIL reset_done: got %b want 1", bus.mult_done); end
    if (bus.busy !== 1'b0)        begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (bus.mult_done !== 1'b1)   begin miscompares++; $display("FAIL post_reset_done: got %b want 1", bus.mult_done); end
    if (bus.busy !== 1'b0)        begin miscompares++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[9];
    logic md0;
    int   lat;
    logic [W-1:0] prev_hi, prev_lo;
    tbl = '{
      '{MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE},
      '{MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1},
      '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{MDU_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF},
      '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
      '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF},
      '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
      '{MDU_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF},
      '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD}
    };
    for (int i = 0; i < 9; i++) begin
      prev_hi = bus.hi_out;
      prev_lo = bus.lo_out;
      issue(tbl[i].op, tbl[i].a, tbl[i].b, md0);
      vectors += 3;
      if (md0 !== 1'b0) begin miscompares++; $display("FAIL dir%0d_done_c0: got %b want 0", i, md0); end
      if (bus.hi_out !== prev_hi || bus.lo_out !== prev_lo) begin
        miscompares++;
        $display("FAIL dir%0d_hold: got %h_%h want %h_%h", i, bus.hi_out, bus.lo_out, prev_hi, prev_lo);
      end
      if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL dir%0d_busy: got %b want 1", i, bus.busy); end
      wait_done(lat);
      vectors += 3;
      if (lat !== 34)              begin miscompares++; $display("FAIL dir%0d_latency: got %0d want 34", i, lat); end
      if (bus.hi_out !== tbl[i].hi) begin miscompares++; $display("FAIL dir%0d_hi: got %h want %h", i, bus.hi_out, tbl[i].hi); end
      if (bus.lo_out !== tbl[i].lo) begin miscompares++; $display("FAIL dir%0d_lo: got %h want %h", i, bus.lo_out, tbl[i].lo); end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic md0;
    int   lat;
    logic [W-1:0] lo_before;
    @(negedge clk);
    bus.start_e = 1'b1; bus.op_e = MDU_MTHI; bus.srca_e = 32'h1234_5678;
    #1;
    vectors++;
    if (bus.mult_done !== 1'b1) begin miscompares++; $display("FAIL mthi_done: got %b want 1", bus.mult_done); end
    @(posedge clk); #1;
    vectors++;
    if (bus.hi_out !== 32'h1234_5678) begin miscompares++; $display("FAIL mthi_hi: got %h want 12345678", bus.hi_out); end
    @(negedge clk);
    bus.op_e = MDU_MTLO; bus.srca_e = 32'hCAFE_F00D;
    @(posedge clk); #1;
    vectors += 2;
    if (bus.lo_out !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL mtlo_lo: got %h want cafef00d", bus.lo_out); end
    if (bus.hi_out !== 32'h1234_5678) begin miscompares++; $display("FAIL mtlo_hi_kept: got %h want 12345678", bus.hi_out); end
    @(negedge clk);
    bus.op_e = 3'b110; bus.srca_e = 32'h5555_5555;
    #1;
    vectors++;
    if (bus.mult_done !== 1'b1) begin miscompares++; $display("FAIL op110_done: got %b want 1", bus.mult_done); end
    @(posedge clk); #1;
    vectors += 3;
    if (bus.hi_out !== 32'h1234_5678) begin miscompares++; $display("FAIL op110_hi: got %h want 12345678", bus.hi_out); end
    if (bus.lo_out !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL op110_lo: got %h want cafef00d", bus.lo_out); end
    if (bus.busy !== 1'b0)            begin miscompares++; $display("FAIL op110_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    bus.start_e = 1'b0;
    // MTLO presented mid-run must be dropped.
    issue(MDU_MULTU, 32'd5, 32'd6, md0);
    @(negedge clk);
    lo_before = bus.lo_out;
    bus.start_e = 1'b1; bus.op_e = MDU_MTLO; bus.srca_e = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start_e = 1'b0;
    vectors++;
    if (bus.lo_out !== lo_before) begin miscompares++; $display("FAIL mtlo_busy_hold: got %h want %h", bus.lo_out, lo_before); end
    wait_done(lat);
    vectors += 2;
    if (bus.lo_out !== 32'd30) begin miscompares++; $display("FAIL mtlo_busy_lo: got %h want 1e", bus.lo_out); end
    if (bus.hi_out !== 32'd0)  begin miscompares++; $display("FAIL mtlo_busy_hi: got %h want 0", bus.hi_out); end
  endtask

  task automatic test_restart_ignored();
    logic md0;
    int   lat;
    logic [W-1:0] ehi, elo;
    logic [W-1:0] a1, b1;
    a1 = 32'hFFFE_1DC0;
    b1 = 32'h0000_0315;
    ref_model(MDU_MULT, a1, b1, ehi, elo);
    issue(MDU_MULT, a1, b1, md0);
    repeat (4) @(negedge clk);
    bus.start_e = 1'b1; bus.op_e = MDU_MULT; bus.srca_e = 32'h0000_0077; bus.srcb_e = 32'h0000_0099;
    @(negedge clk);
    bus.start_e = 1'b0;
    wait_done(lat);
    vectors += 2;
    if (bus.hi_out !== ehi) begin miscompares++; $display("FAIL restart_hi: got %h want %h", bus.hi_out, ehi); end
    if (bus.lo_out !== elo) begin miscompares++; $display("FAIL restart_lo: got %h want %h", bus.lo_out, elo); end
  endtask

  task automatic test_async_reset();
    logic md0;
    int   lat;
    @(negedge clk);
    bus.start_e = 1'b1; bus.op_e = MDU_MTHI; bus.srca_e = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.op_e = MDU_MTLO; bus.srca_e = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.start_e = 1'b0;
    issue(MDU_MULTU, 32'h0001_2345, 32'h0000_6789, md0);
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    vectors += 4;
    if (bus.mult_done !== 1'b1) begin miscompares++; $display("FAIL areset_done: got %b want 1", bus.mult_done); end
    if (bus.busy !== 1'b0)      begin miscompares++; $display("FAIL areset_busy: got %b want 0", bus.busy); end
    if (bus.hi_out !== 32'h0)   begin miscompares++; $display("FAIL areset_hi: got %h want 0", bus.hi_out); end
    if (bus.lo_out !== 32'h0)   begin miscompares++; $display("FAIL areset_lo: got %h want 0", bus.lo_out); end
    @(negedge clk);
    reset = 1'b0;
    issue(MDU_MULTU, 32'd3, 32'd4, md0);
    wait_done(lat);
    vectors += 3;
    if (lat !== 34)           begin miscompares++; $display("FAIL areset_mul_latency: got %0d want 34", lat); end
    if (bus.lo_out !== 32'd12) begin miscompares++; $display("FAIL areset_mul_lo: got %h want c", bus.lo_out); end
    if (bus.hi_out !== 32'd0)  begin miscompares++; $display("FAIL areset_mul_hi: got %h want 0", bus.hi_out); end
  endtask

  task automatic test_random();
    logic md0;
    int   lat;
    int   sel;
    logic [2:0]   op;
    logic [W-1:0] a, b, ehi, elo;
    for (int n = 0; n < 40; n++) begin
      op  = 3'($urandom_range(0, 5));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      if (op[2]) begin
        @(negedge clk);
        bus.start_e = 1'b1; bus.op_e = op; bus.srca_e = a;
        @(posedge clk); #1;
        vectors++;
        if (op == MDU_MTHI && bus.hi_out !== a) begin miscompares++; $display("FAIL rnd%0d_mthi: got %h want %h", n, bus.hi_out, a); end
        if (op == MDU_MTLO && bus.lo_out !== a) begin miscompares++; $display("FAIL rnd%0d_mtlo: got %h want %h", n, bus.lo_out, a); end
        @(negedge clk);
        bus.start_e = 1'b0;
      end else begin
        ref_model(op, a, b, ehi, elo);
        issue(op, a, b, md0);
        wait_done(lat);
        vectors += 4;
        if (md0 !== 1'b0)       begin miscompares++; $display("FAIL rnd%0d_done_c0: got %b want 0", n, md0); end
        if (lat !== 34)         begin miscompares++; $display("FAIL rnd%0d_latency: got %0d want 34", n, lat); end
        if (bus.hi_out !== ehi) begin miscompares++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h want %h", n, op, a, b, bus.hi_out, ehi); end
        if (bus.lo_out !== elo) begin miscompares++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h want %h", n, op, a, b, bus.lo_out, elo); end
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.start_e = 1'b0;
    bus.op_e    = 3'b000;
    bus.srca_e  = '0;
    bus.srcb_e  = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_restart_ignored();
    test_async_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
